// File: rtl/dl_ram_arbiter.sv
// Arbitrates the single-port system RAM between Z80 accesses and buffered HPS download bytes.
// Optional DL_CHECKSUM_EN adds dl_cksum, a mod-256 sum of every download byte written to RAM.
module dl_ram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAM_AW     = 17,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_go,
  input  logic              dn_wr,
  input  logic [24:0]       dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef DL_CHECKSUM_EN
  ,
  output logic [7:0]        dl_cksum
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CPU_WR  = 3'd1;
  localparam logic [2:0] S_CPU_RD  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_DL_WR   = 3'd4;

  logic [2:0]            state;
  logic [2:0]            arb_next;
  logic                  arbitrating;
  logic                  pop;
  logic                  cpu_grant;
  logic                  push_ok;
  logic                  fifo_nonempty;
  logic                  fifo_full;
  logic [RAM_AW+7:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [RAM_AW+7:0]     head;
  logic [SW-1:0]         starve;
  logic [7:0]            rdata_q;
  logic                  dn_go_q;
  logic                  dn_rise;
  logic                  dn_fall;
  logic                  done_pend;
  logic                  land_ok;
  logic                  dn_addr_unused;

  assign dn_addr_unused = ^dn_addr[24:RAM_AW];

  assign fifo_nonempty = (count != '0);
  assign fifo_full     = (count == (PW+1)'(FIFO_DEPTH));
  assign head          = fifo_mem[rd_ptr];
  assign dn_rise       = dn_go & ~dn_go_q;
  assign dn_fall       = ~dn_go & dn_go_q;

  // DL_WR re-arbitrates on its own cycle, so a forced download write costs the CPU one cycle only.
  assign arbitrating = (state == S_IDLE) || (state == S_DL_WR);

  always_comb begin
    arb_next = S_IDLE;
    if ((starve >= SW'(STARVE_MAX)) && fifo_nonempty)
      arb_next = S_DL_WR;
    else if (cpu_req)
      arb_next = cpu_we ? S_CPU_WR : S_CPU_RD;
    else if (fifo_nonempty)
      arb_next = S_DL_WR;
  end

  assign pop       = arbitrating && (arb_next == S_DL_WR);
  assign cpu_grant = arbitrating && ((arb_next == S_CPU_WR) || (arb_next == S_CPU_RD));
  assign push_ok   = dn_wr && (!fifo_full || pop);

  // Read data passes straight through in RD_WAIT so it lines up with cpu_ack, then is held.
  assign cpu_rdata = (state == S_RD_WAIT) ? ram_rdata : rdata_q;
  assign busy      = dn_go | fifo_nonempty | (state == S_DL_WR);
  assign land_ok   = !dn_go && !fifo_nonempty && (state != S_DL_WR);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      cpu_ack   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      ram_we  <= 1'b0;
      ram_re  <= 1'b0;
      cpu_ack <= 1'b0;
      if (arbitrating) begin
        state <= arb_next;
        case (arb_next)
          S_CPU_WR: begin
            ram_we    <= 1'b1;
            cpu_ack   <= 1'b1;
            ram_addr  <= RAM_AW'(cpu_addr);
            ram_wdata <= cpu_wdata;
          end
          S_CPU_RD: begin
            ram_re   <= 1'b1;
            ram_addr <= RAM_AW'(cpu_addr);
          end
          S_DL_WR: begin
            ram_we    <= 1'b1;
            ram_addr  <= head[RAM_AW+7:8];
            ram_wdata <= head[7:0];
          end
          default: ;
        endcase
      end else begin
        case (state)
          S_CPU_RD: begin
            state   <= S_RD_WAIT;
            cpu_ack <= 1'b1;
          end
          S_RD_WAIT: begin
            state   <= S_IDLE;
            rdata_q <= ram_rdata;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= {dn_addr[RAM_AW-1:0], dn_data};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!fifo_nonempty || pop)
        starve <= '0;
      else if (cpu_grant && (starve < SW'(STARVE_MAX)))
        starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dn_go_q   <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      dn_go_q <= dn_go;
      done    <= 1'b0;
      if (dn_wr && fifo_full && !pop)
        overflow <= 1'b1;
      else if (dn_rise)
        overflow <= 1'b0;
      if (dn_rise) begin
        done_pend <= 1'b0;
      end else if (dn_fall) begin
        done_pend <= 1'b1;
      end else if (done_pend && land_ok) begin
        done      <= 1'b1;
        done_pend <= 1'b0;
      end
    end
  end

`ifdef DL_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      dl_cksum <= '0;
    else if (dn_rise)
      dl_cksum <= pop ? head[7:0] : 8'h00;
    else if (pop)
      dl_cksum <= dl_cksum + head[7:0];
  end
`endif

endmodule
